// File: rtl/block_addr_seq_pkg.sv
// ---------------------------------------------------------------------------
// block_addr_seq_pkg
// Shared types and default parameters for the block address sequencer.
//   state_t     : sequencer FSM states (IDLE, RUN, DONE), fixed 2-bit encoding
//   ADDR_W_DEF  : default address width in bits
//   LEN_W_DEF   : default transfer-length width in bits (bytes)
//   STEP_DEF    : default address increment per beat in bytes
// ---------------------------------------------------------------------------
package block_addr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 16;
  localparam int STEP_DEF   = 8;

endpackage

// File: rtl/block_addr_sequencer_beat_counter.sv
// ---------------------------------------------------------------------------
// beat_counter
// Down-counter of bytes still to be addressed in the current run.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   load       : load load_val as the new remaining byte count
//   load_val   : run length in bytes
//   dec        : subtract STEP (one accepted, non-final beat)
//   last       : the beat currently offered is the final one
// ---------------------------------------------------------------------------
module beat_counter
  import block_addr_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [LEN_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  localparam logic [LEN_W-1:0] STEP_L = LEN_W'(STEP);

  logic [LEN_W-1:0] remaining_d, remaining_q;

  // The decrement never underflows: the final beat (remaining <= STEP)
  // ends the run instead of decrementing.
  always_comb begin
    remaining_d = remaining_q;
    if (load) begin
      remaining_d = load_val;
    end else if (dec) begin
      remaining_d = remaining_q - STEP_L;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      remaining_q <= '0;
    end else begin
      remaining_q <= remaining_d;
    end
  end

  // A partial final step (len not a multiple of STEP) still counts as one beat.
  assign last = (remaining_q <= STEP_L);

endmodule

// File: rtl/block_addr_sequencer.sv
// ---------------------------------------------------------------------------
// block_addr_sequencer
// Streams ceil(len/STEP) block addresses, starting at s_addr and stepping by
// STEP bytes, over a valid/ready handshake. One instance per direction.
// Ports:
//   clk, n_rst            : clock, asynchronous active-low reset
//   start, s_addr, len    : begin a run (accepted only in IDLE)
//   abort                 : cancel the run, no done pulse
//   addr_ready            : consumer accepts addr this cycle
//   addr_valid, addr, last: offered beat and final-beat flag
//   busy                  : sequencer not idle
//   done                  : one-cycle completion pulse
// Optional build macro BLOCK_ADDR_SEQ_WRAP_EN adds wrap_base / wrap_limit
// (circular-buffer mode, sampled on an accepted start).
// All outputs decode registered state only.
// ---------------------------------------------------------------------------
module block_addr_sequencer
  import block_addr_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int STEP   = STEP_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              addr_ready,
`ifdef BLOCK_ADDR_SEQ_WRAP_EN
  input  logic [ADDR_W-1:0] wrap_base,
  input  logic [ADDR_W-1:0] wrap_limit,
`endif
  output logic              addr_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              busy,
  output logic              done
);

  state_t            state_d, state_q;
  logic [ADDR_W-1:0] cur_addr_d, cur_addr_q;
  logic [ADDR_W-1:0] addr_step;
  logic              run;
  logic              handshake;
  logic              accept_start;
  logic              cnt_last;

  assign run          = (state_q == RUN);
  assign handshake    = run && addr_ready;
  assign accept_start = (state_q == IDLE) && start && !abort;

`ifdef BLOCK_ADDR_SEQ_WRAP_EN
  logic [ADDR_W-1:0] wrap_base_d, wrap_base_q;
  logic [ADDR_W-1:0] wrap_limit_d, wrap_limit_q;
  logic [ADDR_W:0]   addr_sum;

  // The carry bit takes part in the limit compare, so a step past the
  // top of the address space also counts as exceeding the limit.
  assign addr_sum  = {1'b0, cur_addr_q} + (ADDR_W + 1)'(STEP);
  assign addr_step = (addr_sum > {1'b0, wrap_limit_q}) ? wrap_base_q
                                                       : addr_sum[ADDR_W-1:0];

  always_comb begin
    wrap_base_d  = wrap_base_q;
    wrap_limit_d = wrap_limit_q;
    if (accept_start) begin
      wrap_base_d  = wrap_base;
      wrap_limit_d = wrap_limit;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wrap_base_q  <= '0;
      wrap_limit_q <= '0;
    end else begin
      wrap_base_q  <= wrap_base_d;
      wrap_limit_q <= wrap_limit_d;
    end
  end
`else
  // Plain modulo-2^ADDR_W increment; the address wraps through zero.
  assign addr_step = cur_addr_q + ADDR_W'(STEP);
`endif

  beat_counter #(
    .LEN_W (LEN_W),
    .STEP  (STEP)
  ) u_beat_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (accept_start && (len != '0)),
    .load_val (len),
    .dec      (handshake && !abort && !cnt_last),
    .last     (cnt_last)
  );

  // abort wins over both a same-cycle handshake and an IDLE start.
  // DONE always lasts a single cycle, so abort there changes nothing.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    case (state_q)
      IDLE: begin
        if (accept_start) begin
          if (len != '0) begin
            state_d    = RUN;
            cur_addr_d = s_addr;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (handshake) begin
          if (cnt_last) begin
            state_d = DONE;
          end else begin
            cur_addr_d = addr_step;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  assign addr_valid = run;
  assign addr       = run ? cur_addr_q : '0;
  assign last       = run && cnt_last;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_block_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_block_addr_sequencer
// Self-checking bench for block_addr_sequencer (ADDR_W=16, LEN_W=16, STEP=8).
// A behavioural model expands every accepted start into the full list of
// expected beat addresses; a negedge process compares all outputs against
// it every cycle. Directed runs pin literal address sequences, then a
// randomized phase exercises start/abort/ready interleavings.
// Honours BLOCK_ADDR_SEQ_WRAP_EN for the circular-buffer ports.
// ---------------------------------------------------------------------------
module tb_block_addr_sequencer;

  localparam int STEP = 8;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        abort;
  logic [15:0] s_addr;
  logic [15:0] len;
  logic        addr_ready;
  logic [15:0] wrap_base;
  logic [15:0] wrap_limit;
  logic        addr_valid;
  logic [15:0] addr;
  logic        last;
  logic        busy;
  logic        done;

  int n_compared;
  int n_mismatched;

  block_addr_sequencer #(
    .ADDR_W (16),
    .LEN_W  (16),
    .STEP   (STEP)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .abort      (abort),
    .s_addr     (s_addr),
    .len        (len),
    .addr_ready (addr_ready),
`ifdef BLOCK_ADDR_SEQ_WRAP_EN
    .wrap_base  (wrap_base),
    .wrap_limit (wrap_limit),
`endif
    .addr_valid (addr_valid),
    .addr       (addr),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Behavioural model: a run is the list of addresses still to be
  // accepted; phase 0 = idle, 1 = offering addresses, 2 = done pulse.
  logic [15:0] exp_q[$];
  int          phase;

  function automatic void build_run(input logic [15:0] sa, input logic [15:0] ln);
    int n;
    int a;
    n = (int'(ln) + STEP - 1) / STEP;
    a = int'(sa);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a[15:0]);
`ifdef BLOCK_ADDR_SEQ_WRAP_EN
      if (a + STEP > int'(wrap_limit)) a = int'(wrap_base);
      else a = a + STEP;
`else
      a = (a + STEP) % 65536;
`endif
    end
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase = 0;
      exp_q.delete();
    end else begin
      case (phase)
        0: if (start && !abort) begin
             build_run(s_addr, len);
             phase = (exp_q.size() == 0) ? 2 : 1;
           end
        1: if (abort) begin
             exp_q.delete();
             phase = 0;
           end else if (addr_ready) begin
             void'(exp_q.pop_front());
             if (exp_q.size() == 0) phase = 2;
           end
        default: phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    checkOutput("model_valid", {31'd0, addr_valid}, {31'd0, phase == 1});
    checkOutput("model_addr", {16'd0, addr}, (phase == 1) ? {16'd0, exp_q[0]} : 32'd0);
    checkOutput("model_last", {31'd0, last}, {31'd0, (phase == 1) && (exp_q.size() == 1)});
    checkOutput("model_busy", {31'd0, busy}, {31'd0, phase != 0});
    checkOutput("model_done", {31'd0, done}, {31'd0, phase == 2});
  end

  // Drive one cycle of inputs, then advance to the next negedge.
  task automatic applyStimulus(input logic st, input logic ab, input logic rdy,
                               input logic [15:0] sa, input logic [15:0] ln);
    start      = st;
    abort      = ab;
    addr_ready = rdy;
    s_addr     = sa;
    len        = ln;
    @(negedge clk);
  endtask

  logic [15:0] lit[8];

  // Start a run with addr_ready held high and check each beat against lit[].
  task automatic directedRun(input string tag, input logic [15:0] sa,
                             input logic [15:0] ln, input int n);
    applyStimulus(1'b1, 1'b0, 1'b1, sa, ln);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_valid"}, {31'd0, addr_valid}, 32'd1);
      checkOutput({tag, "_addr"}, {16'd0, addr}, {16'd0, lit[i]});
      checkOutput({tag, "_last"}, {31'd0, last}, {31'd0, i == n - 1});
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    end
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_valid_off"}, {31'd0, addr_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done_fall"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    n_rst        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    addr_ready   = 1'b0;
    s_addr       = 16'h0;
    len          = 16'h0;
    wrap_base    = 16'h0000;
    wrap_limit   = 16'hFFFF;
    repeat (2) @(negedge clk);
    checkOutput("reset_valid", {31'd0, addr_valid}, 32'd0);
    checkOutput("reset_addr", {16'd0, addr}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    n_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Four full beats.
    lit[0] = 16'h0100; lit[1] = 16'h0108; lit[2] = 16'h0110; lit[3] = 16'h0118;
    directedRun("t1", 16'h0100, 16'd32, 4);

    // Partial last step still gives a full beat.
    directedRun("t2", 16'h0100, 16'd20, 3);

    // Stall three cycles on 0x0108.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0100, 16'd32);
    checkOutput("t3_addr0", {16'd0, addr}, 32'h0100);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t3_stall_valid", {31'd0, addr_valid}, 32'd1);
      checkOutput("t3_stall_addr", {16'd0, addr}, 32'h0108);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    end
    checkOutput("t3_hold_addr", {16'd0, addr}, 32'h0108);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput("t3_resume_addr", {16'd0, addr}, 32'h0110);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput("t3_last_addr", {16'd0, addr}, 32'h0118);
    checkOutput("t3_last", {31'd0, last}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput("t3_done", {31'd0, done}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);

    // Abort after two handshakes, overriding a same-cycle handshake.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0100, 16'd32);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput("t4_pre_abort_addr", {16'd0, addr}, 32'h0110);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
    checkOutput("t4_abort_valid", {31'd0, addr_valid}, 32'd0);
    checkOutput("t4_abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("t4_abort_done", {31'd0, done}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput("t4_no_done", {31'd0, done}, 32'd0);
    lit[0] = 16'h0400;
    directedRun("t4_restart", 16'h0400, 16'd8, 1);

    // abort beats start in IDLE.
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0300, 16'd16);
    checkOutput("idle_abort_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);

    // Zero length: done one cycle after start, no address.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0500, 16'd0);
    checkOutput("t5_len0_valid", {31'd0, addr_valid}, 32'd0);
    checkOutput("t5_len0_done", {31'd0, done}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput("t5_len0_idle", {31'd0, busy}, 32'd0);

    // Address wraps through zero.
    lit[0] = 16'hFFF8; lit[1] = 16'h0000;
    directedRun("t5_wrap0", 16'hFFF8, 16'd16, 2);

    // Asynchronous reset in the middle of a run.
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0800, 16'd64);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("rst_mid_valid", {31'd0, addr_valid}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput("rst_mid_no_done", {31'd0, done}, 32'd0);

`ifdef BLOCK_ADDR_SEQ_WRAP_EN
    wrap_base  = 16'h0200;
    wrap_limit = 16'h020F;
    lit[0] = 16'h0208; lit[1] = 16'h0200; lit[2] = 16'h0208; lit[3] = 16'h0200;
    directedRun("t6_circ", 16'h0208, 16'd32, 4);
    wrap_base  = 16'h0000;
    wrap_limit = 16'hFFFF;
`endif

    // Randomized phase checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
`ifdef BLOCK_ADDR_SEQ_WRAP_EN
      wrap_base  = 16'($urandom_range(0, 255)) << 3;
      wrap_limit = wrap_base + 16'($urandom_range(8, 96));
`endif
      applyStimulus(($urandom % 4) == 0, ($urandom % 40) == 0,
                    ($urandom % 3) != 0, 16'($urandom),
                    16'($urandom_range(0, 100)));
    end

    // Let any open run drain under the model's watch.
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    end
    checkOutput("drain_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
